vfu_result_wb_arbiter: RTL and testbench

- Per-lane writeback stage directly downstream of the vector functional-unit stage.
- Accepts the ALU and MFPU result write requests, buffers each in its own small FIFO, and arbitrates them round-robin onto a single VRF write port using req/gnt.
- Also exports a per-instruction "writes in flight" mask, so the lane sequencer does not retire an instruction while its results are still buffered.

---
 rtl/vfu_result_wb_arbiter_pkg.sv | 11 +
 rtl/vfu_result_wb_arbiter_fifo.sv | 43 ++++
 rtl/vfu_result_wb_arbiter.sv | 108 ++++++++++
 tb/tb_vfu_result_wb_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vfu_result_wb_arbiter_pkg.sv
// vfu_result_wb_arbiter_pkg: shared types for the VFU result writeback arbiter.
package vfu_result_wb_arbiter_pkg;
    localparam int unsigned NrVInsn = 8;
    localparam int unsigned ELEN = 64;
    typedef logic [$clog2(NrVInsn)-1:0] vid_t;
    typedef logic [ELEN-1:0] elen_t;
    typedef enum logic {WbSrcAlu = 1'b0, WbSrcMfpu = 1'b1} wb_src_e;
    function automatic logic [NrVInsn-1:0] vid_onehot(vid_t id);
        return {{(NrVInsn-1){1'b0}}, 1'b1} << id;
    endfunction
endpackage

// File: rtl/vfu_result_wb_arbiter_fifo.sv
// vfu_wb_fifo: register-array FIFO exposing every slot and its valid bit.
module vfu_wb_fifo #(
    parameter int unsigned Depth = 2,
    parameter type dtype = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  dtype             data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output dtype             head,
    output logic [Depth-1:0] valid,
    output dtype             entries [Depth]
);
    localparam int unsigned PtrW = $clog2(Depth);
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic push_en, pop_en;
    dtype mem [Depth];
    assign full    = &valid;
    assign empty   = ~|valid;
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;
    // Slot validity is tracked per entry so the owner can scan all buffered ids.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            for (int i = 0; i < Depth; i++)
                valid[i] <= (valid[i] & ~(pop_en & (rd_ptr == PtrW'(i)))) | (push_en & (wr_ptr == PtrW'(i)));
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_en) mem[wr_ptr] <= data;
    end
endmodule

// File: rtl/vfu_result_wb_arbiter.sv
// vfu_result_wb_arbiter: buffers ALU/MFPU results and round-robins them onto one VRF write port.
module vfu_result_wb_arbiter
    import vfu_result_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrLanes   = 0,
    parameter type         vaddr_t   = logic,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_result_req_i,
    input  vid_t                 alu_result_id_i,
    input  vaddr_t               alu_result_addr_i,
    input  elen_t                alu_result_wdata_i,
    input  logic [ELEN/8-1:0]    alu_result_be_i,
    output logic                 alu_result_gnt_o,
    input  logic                 mfpu_result_req_i,
    input  vid_t                 mfpu_result_id_i,
    input  vaddr_t               mfpu_result_addr_i,
    input  elen_t                mfpu_result_wdata_i,
    input  logic [ELEN/8-1:0]    mfpu_result_be_i,
    output logic                 mfpu_result_gnt_o,
    output logic                 vrf_req_o,
    output vid_t                 vrf_id_o,
    output vaddr_t               vrf_addr_o,
    output elen_t                vrf_wdata_o,
    output logic [ELEN/8-1:0]    vrf_be_o,
    output logic                 vrf_src_o,
    input  logic                 vrf_gnt_i,
    output logic [NrVInsn-1:0]   wb_pending_o
);
    localparam int unsigned DataWidth = $bits(elen_t);
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef struct packed {
        vid_t   id;
        vaddr_t addr;
        elen_t  wdata;
        strb_t  be;
    } wb_entry_t;
    wb_entry_t alu_in, mfpu_in, alu_head, mfpu_head, sel_head;
    wb_entry_t alu_entries [FifoDepth];
    wb_entry_t mfpu_entries [FifoDepth];
    logic [FifoDepth-1:0] alu_valid, mfpu_valid;
    logic alu_full, alu_empty, mfpu_full, mfpu_empty, lock_q, wr_fire;
    wb_src_e sel, lock_src_q, rr_last_q;
    assign alu_in  = '{id: alu_result_id_i, addr: alu_result_addr_i, wdata: alu_result_wdata_i, be: alu_result_be_i};
    assign mfpu_in = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i, wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};
    // Grants look only at local FIFO state, keeping the VRF grant off the FU path.
    assign alu_result_gnt_o  = rst_ni & alu_result_req_i & ~alu_full;
    assign mfpu_result_gnt_o = rst_ni & mfpu_result_req_i & ~mfpu_full;
    vfu_wb_fifo #(.Depth(FifoDepth), .dtype(wb_entry_t)) i_alu_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (alu_result_gnt_o),
        .data    (alu_in),
        .pop     (wr_fire && sel == WbSrcAlu),
        .full    (alu_full),
        .empty   (alu_empty),
        .head    (alu_head),
        .valid   (alu_valid),
        .entries (alu_entries)
    );
    vfu_wb_fifo #(.Depth(FifoDepth), .dtype(wb_entry_t)) i_mfpu_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (mfpu_result_gnt_o),
        .data    (mfpu_in),
        .pop     (wr_fire && sel == WbSrcMfpu),
        .full    (mfpu_full),
        .empty   (mfpu_empty),
        .head    (mfpu_head),
        .valid   (mfpu_valid),
        .entries (mfpu_entries)
    );
    always_comb begin
        sel = WbSrcAlu;
        if (lock_q) sel = lock_src_q;
        else if (!alu_empty && !mfpu_empty) sel = (rr_last_q == WbSrcAlu) ? WbSrcMfpu : WbSrcAlu;
        else if (!mfpu_empty) sel = WbSrcMfpu;
    end
    assign vrf_req_o   = ~alu_empty | ~mfpu_empty;
    assign wr_fire     = vrf_req_o & vrf_gnt_i;
    assign sel_head    = (sel == WbSrcMfpu) ? mfpu_head : alu_head;
    assign vrf_id_o    = vrf_req_o ? sel_head.id : '0;
    assign vrf_addr_o  = vrf_req_o ? sel_head.addr : '0;
    assign vrf_wdata_o = vrf_req_o ? sel_head.wdata : '0;
    assign vrf_be_o    = vrf_req_o ? sel_head.be : '0;
    assign vrf_src_o   = vrf_req_o & (sel == WbSrcMfpu);
    // A stalled write keeps its source so the presented fields cannot change before the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= WbSrcAlu;
            rr_last_q  <= WbSrcAlu;
        end else begin
            lock_q <= vrf_req_o & ~vrf_gnt_i;
            if (vrf_req_o && !vrf_gnt_i) lock_src_q <= sel;
            if (wr_fire) rr_last_q <= sel;
        end
    end
    always_comb begin
        wb_pending_o = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            if (alu_valid[i]) wb_pending_o = wb_pending_o | vid_onehot(alu_entries[i].id);
            if (mfpu_valid[i]) wb_pending_o = wb_pending_o | vid_onehot(mfpu_entries[i].id);
        end
    end
endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// tb_vfu_result_wb_arbiter: directed scoreboard bench for the VFU writeback arbiter.
module tb_vfu_result_wb_arbiter;
    typedef struct packed {
        logic [2:0]  id;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        src;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic alu_req = 1'b0, mfpu_req = 1'b0, vrf_gnt = 1'b0;
    logic [2:0] alu_id = '0, mfpu_id = '0;
    logic [7:0] alu_addr = '0, mfpu_addr = '0, alu_be = '0, mfpu_be = '0;
    logic [63:0] alu_wdata = '0, mfpu_wdata = '0;
    logic alu_gnt, mfpu_gnt, vrf_req, vrf_src;
    logic [2:0] vrf_id;
    logic [7:0] vrf_addr, vrf_be, wb_pending;
    logic [63:0] vrf_wdata;
    int checks = 0, failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vfu_result_wb_arbiter #(.NrLanes(0), .vaddr_t(logic [7:0]), .FifoDepth(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alu_result_req_i(alu_req), .alu_result_id_i(alu_id), .alu_result_addr_i(alu_addr),
        .alu_result_wdata_i(alu_wdata), .alu_result_be_i(alu_be), .alu_result_gnt_o(alu_gnt),
        .mfpu_result_req_i(mfpu_req), .mfpu_result_id_i(mfpu_id), .mfpu_result_addr_i(mfpu_addr),
        .mfpu_result_wdata_i(mfpu_wdata), .mfpu_result_be_i(mfpu_be), .mfpu_result_gnt_o(mfpu_gnt),
        .vrf_req_o(vrf_req), .vrf_id_o(vrf_id), .vrf_addr_o(vrf_addr), .vrf_wdata_o(vrf_wdata),
        .vrf_be_o(vrf_be), .vrf_src_o(vrf_src), .vrf_gnt_i(vrf_gnt), .wb_pending_o(wb_pending)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic r, input logic [2:0] id, input logic [7:0] a, input logic [63:0] d, input logic [7:0] b);
        alu_req = r; alu_id = id; alu_addr = a; alu_wdata = d; alu_be = b;
    endtask

    task automatic set_mfpu(input logic r, input logic [2:0] id, input logic [7:0] a, input logic [63:0] d, input logic [7:0] b);
        mfpu_req = r; mfpu_id = id; mfpu_addr = a; mfpu_wdata = d; mfpu_be = b;
    endtask

    // Every accepted VRF write must match the head of the expected-order queue.
    always @(negedge clk) begin
        if (rst_n && vrf_req && vrf_gnt) begin
            if (sb.size() == 0) chk("unexpected_write", {vrf_id, vrf_addr, vrf_wdata, vrf_be, vrf_src}, 0);
            else chk("write", {vrf_id, vrf_addr, vrf_wdata, vrf_be, vrf_src}, sb.pop_front());
        end
    end

    initial begin
        alu_req = 1'b1;
        #2;
        chk("rst_vrf_req", vrf_req, 0);
        chk("rst_alu_gnt", alu_gnt, 0);
        chk("rst_pending", wb_pending, 0);
        chk("rst_fields", {vrf_id, vrf_addr, vrf_wdata, vrf_be, vrf_src}, 0);
        alu_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // ALU only
        step();
        vrf_gnt = 1'b1;
        set_alu(1, 3'd3, 8'h10, 64'hDEADBEEF, 8'hFF);
        #1;
        chk("t1_alu_gnt", alu_gnt, 1);
        sb.push_back('{3'd3, 8'h10, 64'hDEADBEEF, 8'hFF, 1'b0});
        step();
        set_alu(0, 0, 0, 0, 0);
        #1;
        chk("t1_req_t1", vrf_req, 1);
        chk("t1_src_t1", vrf_src, 0);
        chk("t1_pending_t1", wb_pending, 8'h08);
        step();
        chk("t1_req_t2", vrf_req, 0);
        chk("t1_pending_t2", wb_pending, 8'h00);

        // Round-robin with both FIFOs full
        vrf_gnt = 1'b0;
        set_alu(1, 3'd1, 8'hA0, 64'hA0A0, 8'h0F);
        set_mfpu(1, 3'd2, 8'hB0, 64'hB0B0, 8'hF0);
        step();
        set_alu(1, 3'd1, 8'hA1, 64'hA1A1, 8'h03);
        set_mfpu(1, 3'd2, 8'hB1, 64'hB1B1, 8'h30);
        step();
        set_alu(0, 0, 0, 0, 0);
        set_mfpu(0, 0, 0, 0, 0);
        #1;
        chk("rr_pending", wb_pending, 8'h06);
        sb.push_back('{3'd2, 8'hB0, 64'hB0B0, 8'hF0, 1'b1});
        sb.push_back('{3'd1, 8'hA0, 64'hA0A0, 8'h0F, 1'b0});
        sb.push_back('{3'd2, 8'hB1, 64'hB1B1, 8'h30, 1'b1});
        sb.push_back('{3'd1, 8'hA1, 64'hA1A1, 8'h03, 1'b0});
        vrf_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk("rr_req", vrf_req, 1);
            chk("rr_src", vrf_src, (k % 2 == 0) ? 1 : 0);
        end
        step();
        chk("rr_done", vrf_req, 0);

        // MFPU write so the pointer now points at MFPU
        set_mfpu(1, 3'd7, 8'hC7, 64'hC7C7, 8'h77);
        sb.push_back('{3'd7, 8'hC7, 64'hC7C7, 8'h77, 1'b1});
        step();
        set_mfpu(0, 0, 0, 0, 0);
        step();

        // Lock stability: an ALU arrival must not steal a stalled MFPU write
        vrf_gnt = 1'b0;
        set_mfpu(1, 3'd5, 8'h55, 64'h5555_0000, 8'h5A);
        sb.push_back('{3'd5, 8'h55, 64'h5555_0000, 8'h5A, 1'b1});
        step();
        set_mfpu(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            if (k == 1) begin
                set_alu(1, 3'd6, 8'h66, 64'h6666, 8'h06);
                sb.push_back('{3'd6, 8'h66, 64'h6666, 8'h06, 1'b0});
            end else set_alu(0, 0, 0, 0, 0);
            #1;
            chk("lock_fields", {vrf_req, vrf_id, vrf_addr, vrf_wdata, vrf_be, vrf_src},
                {1'b1, 3'd5, 8'h55, 64'h5555_0000, 8'h5A, 1'b1});
        end
        step();
        vrf_gnt = 1'b1;
        #1;
        chk("lock_grant_src", vrf_src, 1);
        step();
        chk("lock_next_alu", {vrf_req, vrf_src, vrf_id}, {1'b1, 1'b0, 3'd6});
        step();
        chk("lock_drained", vrf_req, 0);

        // Backpressure on the ALU FIFO
        vrf_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            set_alu(1, 3'(k), 8'(8'h20 + k), 64'(64'h1000 + k), 8'(k + 1));
            if (k == 3) vrf_gnt = 1'b1;
            #1;
            chk("bp_alu_gnt", alu_gnt, (k < 2 || k == 4) ? 1 : 0);
            if (k < 2 || k == 4) sb.push_back('{3'(k), 8'(8'h20 + k), 64'(64'h1000 + k), 8'(k + 1), 1'b0});
        end
        step();
        set_alu(0, 0, 0, 0, 0);
        step();
        step();
        chk("bp_drained", vrf_req, 0);

        // Concurrent push and pop at occupancy 1
        set_alu(1, 3'd1, 8'h31, 64'h3131, 8'h11);
        sb.push_back('{3'd1, 8'h31, 64'h3131, 8'h11, 1'b0});
        step();
        set_alu(1, 3'd4, 8'h34, 64'h3434, 8'h44);
        sb.push_back('{3'd4, 8'h34, 64'h3434, 8'h44, 1'b0});
        #1;
        chk("pp_pending_a", wb_pending, 8'h02);
        chk("pp_head_a", vrf_id, 3'd1);
        step();
        set_alu(0, 0, 0, 0, 0);
        #1;
        chk("pp_pending_b", wb_pending, 8'h10);
        chk("pp_head_b", {vrf_req, vrf_id}, {1'b1, 3'd4});
        step();
        chk("pp_empty", {vrf_req, wb_pending}, 0);

        // Reset with both FIFOs full
        vrf_gnt = 1'b0;
        set_alu(1, 3'd1, 8'h41, 64'h4141, 8'h01);
        set_mfpu(1, 3'd2, 8'h42, 64'h4242, 8'h02);
        step();
        set_alu(1, 3'd3, 8'h43, 64'h4343, 8'h03);
        set_mfpu(1, 3'd4, 8'h44, 64'h4444, 8'h04);
        step();
        chk("full_gnts", {alu_gnt, mfpu_gnt}, 0);
        chk("full_pending", wb_pending, 8'h1E);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", vrf_req, 0);
        chk("arst_gnts", {alu_gnt, mfpu_gnt}, 0);
        chk("arst_pending", wb_pending, 0);
        set_alu(0, 0, 0, 0, 0);
        set_mfpu(0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        vrf_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_idle", {vrf_req, wb_pending}, 0);
        end
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
